inst_mem_loader: RTL and testbench
==================================

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 SHALL have parameter INST_WIDTH, default 32, meaning instruction word width in bits.
REQ-002 SHALL have parameter INST_ADDR_WIDTH, default 32, meaning width of the word-address output.
REQ-003 SHALL have parameter NUM_WORDS, default 128, meaning instruction memory depth in words.
REQ-004 SHALL have localparam LEN_W = $clog2(NUM_WORDS)+1.
REQ-005 SHALL have port cpu_clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-006 SHALL have port cpu_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port load_start, input, 1 bit: single-cycle request to begin a load.
REQ-008 SHALL have port load_len, input, LEN_W bits: word count, sampled with load_start.
REQ-009 SHALL have port src_valid, input, 1 bit: source word available.
REQ-010 SHALL have port src_data, input, INST_WIDTH bits: source word.
REQ-011 SHALL have port src_ready, output, 1 bit: loader accepts a word this cycle.
REQ-012 SHALL have port dma_inst_mem_waddr, output, INST_ADDR_WIDTH bits: word index to write.
REQ-013 SHALL have port dma_inst_mem_wdata, output, INST_WIDTH bits: write data.
REQ-014 SHALL have port inst_mem_write, output, 1 bit: write strobe to instruction memory.
REQ-015 SHALL have port cpu_hold, output, 1 bit: CPU must stall fetch while high.
REQ-016 SHALL have port load_busy, output, 1 bit: high in any state except IDLE.
REQ-017 SHALL have port load_done, output, 1 bit: one-cycle pulse on successful completion.
REQ-018 SHALL have port load_err, output, 1 bit: one-cycle pulse on a rejected request.

Function
REQ-019 SHALL implement FSM states IDLE, LOAD, FLUSH, DONE and ERR; all outputs SHALL be registered.
REQ-020 IDLE transitions: load_start with 1<=load_len<=NUM_WORDS -> LOAD; load_start with len 0 or len>NUM_WORDS -> ERR; otherwise remain in IDLE.
REQ-021 On entering LOAD, word counter SHALL clear to 0 and remaining count SHALL load from load_len.
REQ-022 src_ready SHALL be 1 only in LOAD.
REQ-023 A word SHALL be accepted when src_valid && src_ready.
REQ-024 Each accepted word SHALL drive inst_mem_write=1 in the next cycle, with waddr equal to the counter value at acceptance and wdata equal to that word; latency SHALL be 1 cycle.
REQ-025 Address SHALL increment by 1 per accepted word and never wrap; the maximum address is NUM_WORDS-1.
REQ-026 src_valid low in LOAD SHALL insert a bubble: no write, no counter change.
REQ-027 Acceptance of the last word SHALL transition to FLUSH and drop src_ready the same edge.
REQ-028 FLUSH SHALL last 1 cycle and issue the last write.
REQ-029 DONE SHALL last 1 cycle with load_done=1, then return to IDLE.
REQ-030 ERR SHALL last 1 cycle with load_err=1 and issue no writes, then return to IDLE.
REQ-031 cpu_hold SHALL be 1 in LOAD, FLUSH and DONE, and 0 in IDLE and ERR.
REQ-032 load_start while load_busy SHALL be ignored.
REQ-033 inst_mem_write SHALL be 0 in every state except the cycle after an acceptance.
REQ-034 waddr and wdata SHALL hold their last values when no write is issued.

Reset
REQ-035 On cpu_rst, the FSM SHALL go to IDLE and all outputs, counters and (if present) the checksum SHALL clear to 0.
REQ-036 cpu_rst in mid-load SHALL abort the load with no load_done; memory words already written SHALL remain.
REQ-037 cpu_rst SHALL take priority over load_start in the same cycle.

Configuration
REQ-038 Macro INST_MEM_LOADER_CHECKSUM_EN, when defined, SHALL add output load_csum (INST_WIDTH bits).
REQ-039 load_csum SHALL be the modulo-2^INST_WIDTH sum of accepted words, cleared on entering LOAD, and stable from DONE until the next load.
REQ-040 Without INST_MEM_LOADER_CHECKSUM_EN, the port and adder SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-041 Package inst_mem_loader_pkg SHALL hold the state encoding (IDLE=0, LOAD=1, FLUSH=2, DONE=3, ERR=4, 3 bits).
REQ-042 The block SHALL be a single module with no sub-module.

Verification
REQ-043 Reset, then load_start with len=3 and words 0x11,0x22,0x33 back-to-back -> writes at addr 0,1,2 on consecutive cycles; load_done 1 cycle after the last write; cpu_hold high throughout.
REQ-044 len=2 with src_valid gapped by 2 idle cycles -> exactly 2 writes (addr 0,1), no write during the gap.
REQ-045 len=0 and len=NUM_WORDS+1 -> load_err pulse, cpu_hold 0, zero writes.
REQ-046 len=NUM_WORDS with a full stream -> last write at addr 127; load_start during LOAD ignored.
REQ-047 cpu_rst asserted after 2 of 5 words -> IDLE next cycle, outputs 0, no load_done.
REQ-048 With checksum enabled, words 0xFFFFFFFF and 0x00000002 -> load_csum=0x00000001 at load_done.

Source files
------------

// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding.
package inst_mem_loader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: streams LEN words from a valid/ready source into
// instruction memory at word addresses 0..LEN-1 while holding the CPU.
// Every output is a flop. Writes appear one cycle after the word is accepted.
// Optional feature: define INST_MEM_LOADER_CHECKSUM_EN to add the load_csum
// output (modulo-2^INST_WIDTH sum of the words accepted in the current load).
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int NUM_WORDS       = 128,
  localparam int LEN_W          = $clog2(NUM_WORDS) + 1
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       load_start,
  input  logic [LEN_W-1:0]           load_len,
  input  logic                       src_valid,
  input  logic [INST_WIDTH-1:0]      src_data,
  output logic                       src_ready,
  output logic [INST_ADDR_WIDTH-1:0] dma_inst_mem_waddr,
  output logic [INST_WIDTH-1:0]      dma_inst_mem_wdata,
  output logic                       inst_mem_write,
  output logic                       cpu_hold,
  output logic                       load_busy,
  output logic                       load_done,
  output logic                       load_err
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  ,
  output logic [INST_WIDTH-1:0]      load_csum
`endif
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(NUM_WORDS);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  state_t                     state_q, state_d;
  logic [LEN_W-1:0]           cnt_q, cnt_d;      // address of the next word
  logic [LEN_W-1:0]           rem_q, rem_d;      // words still to accept
  logic                       src_ready_q, src_ready_d;
  logic                       wr_q, wr_d;
  logic [INST_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [INST_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       hold_q, hold_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;
  logic                       err_q, err_d;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [INST_WIDTH-1:0]      csum_q, csum_d;
`endif

  logic accept;
  logic len_ok;

  assign accept = src_ready_q && src_valid;
  assign len_ok = (load_len != '0) && (load_len <= MAX_LEN);

  // Next-state logic; status outputs are decoded from the next state so the
  // registered versions line up exactly with the state they describe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    wr_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (load_start) begin
          if (len_ok) begin
            state_d = LOAD;
            cnt_d   = '0;
            rem_d   = load_len;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            csum_d  = '0;
`endif
          end else begin
            state_d = ERR;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          wr_d    = 1'b1;
          waddr_d = INST_ADDR_WIDTH'(cnt_q);
          wdata_d = src_data;
          cnt_d   = cnt_q + ONE;
          rem_d   = rem_q - ONE;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
          csum_d  = csum_q + src_data;
`endif
          if (rem_q == ONE) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    src_ready_d = (state_d == LOAD);
    hold_d      = (state_d == LOAD) || (state_d == FLUSH) || (state_d == DONE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    err_d       = (state_d == ERR);
  end

  // State and output registers with synchronous reset that wins over everything.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      src_ready_q <= 1'b0;
      wr_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      hold_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      src_ready_q <= src_ready_d;
      wr_q        <= wr_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign src_ready          = src_ready_q;
  assign dma_inst_mem_waddr = waddr_q;
  assign dma_inst_mem_wdata = wdata_q;
  assign inst_mem_write     = wr_q;
  assign cpu_hold           = hold_q;
  assign load_busy          = busy_q;
  assign load_done          = done_q;
  assign load_err           = err_q;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  assign load_csum          = csum_q;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Scoreboard bench for inst_mem_loader. The driver predicts, from the load
// rules, which write each accepted word must produce (i-th word -> address i,
// one cycle later) and which done/err pulse ends each request; a negedge
// monitor pops and compares whenever the DUT writes or pulses.
// Honors INST_MEM_LOADER_CHECKSUM_EN to also check load_csum at load_done.
module tb_inst_mem_loader;

  localparam int NW = 128;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        load_start;
  logic [7:0]  load_len;
  logic        src_valid;
  logic [31:0] src_data;
  logic        src_ready;
  logic [31:0] dma_inst_mem_waddr;
  logic [31:0] dma_inst_mem_wdata;
  logic        inst_mem_write;
  logic        cpu_hold;
  logic        load_busy;
  logic        load_done;
  logic        load_err;
`ifdef INST_MEM_LOADER_CHECKSUM_EN
  logic [31:0] load_csum;
`endif

  inst_mem_loader #(
    .INST_WIDTH(32),
    .INST_ADDR_WIDTH(32),
    .NUM_WORDS(NW)
  ) dut (
    .cpu_clk(cpu_clk),
    .cpu_rst(cpu_rst),
    .load_start(load_start),
    .load_len(load_len),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .dma_inst_mem_waddr(dma_inst_mem_waddr),
    .dma_inst_mem_wdata(dma_inst_mem_wdata),
    .inst_mem_write(inst_mem_write),
    .cpu_hold(cpu_hold),
    .load_busy(load_busy),
    .load_done(load_done),
    .load_err(load_err)
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    ,
    .load_csum(load_csum)
`endif
  );

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    int          kind;   // 1 = done, 2 = err
    logic [31:0] csum;
    int          cyc;
  } ev_t;

  wr_t         wr_q[$];
  ev_t         ev_q[$];
  logic [31:0] word_tab[$];

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   mon_en = 0;
  bit   rst_pend = 0;
  bit   prev_write = 0;
  logic [31:0] held_a = 0;
  logic [31:0] held_d = 0;

  initial cpu_clk = 0;
  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_src_ready"}, src_ready, 0);
    chk({tag, "_write"}, inst_mem_write, 0);
    chk({tag, "_waddr"}, dma_inst_mem_waddr, 0);
    chk({tag, "_wdata"}, dma_inst_mem_wdata, 0);
    chk({tag, "_hold"}, cpu_hold, 0);
    chk({tag, "_busy"}, load_busy, 0);
    chk({tag, "_done"}, load_done, 0);
    chk({tag, "_err"}, load_err, 0);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
    chk({tag, "_csum"}, load_csum, 0);
`endif
  endtask

  // Monitor: compare every write and every done/err pulse against the queues.
  always @(negedge cpu_clk) begin
    wr_t w;
    ev_t e;
    if (mon_en) begin
      if (rst_pend) begin
        held_a = 0;
        held_d = 0;
        rst_pend = 0;
      end
      if (cpu_rst) rst_pend = 1;
      if (inst_mem_write) begin
        chk("wr_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          chk("wr_addr", dma_inst_mem_waddr, w.addr);
          chk("wr_data", dma_inst_mem_wdata, w.data);
          chk("wr_cycle", cyc, w.cyc);
        end
        chk("wr_hold", cpu_hold, 1);
        held_a = dma_inst_mem_waddr;
        held_d = dma_inst_mem_wdata;
      end else begin
        chk("idle_waddr_held", dma_inst_mem_waddr, held_a);
        chk("idle_wdata_held", dma_inst_mem_wdata, held_d);
      end
      if (load_done || load_err) begin
        chk("ev_expected", ev_q.size() > 0, 1);
        if (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          chk("ev_kind", load_err ? 2 : 1, e.kind);
          chk("ev_cycle", cyc, e.cyc);
          if (e.kind == 1) begin
            chk("done_after_last_wr", prev_write, 1);
            chk("done_hold", cpu_hold, 1);
`ifdef INST_MEM_LOADER_CHECKSUM_EN
            chk("done_csum", load_csum, e.csum);
`endif
          end else begin
            chk("err_hold", cpu_hold, 0);
          end
        end
      end
      prev_write = inst_mem_write;
    end
  end

  // Issue one load request. mode 0: back-to-back, 1: random bubbles,
  // 2: two idle cycles after the first word. spur pulses load_start during LOAD.
  // abort_after > 0 applies cpu_rst right after that many words were accepted.
  task automatic run_load(input int len, input int mode, input bit spur, input int abort_after);
    int          i;
    int          guard;
    int          gap_left;
    int          last_cyc;
    bit          rdy;
    bit          bubble;
    bit          ok;
    logic [31:0] sum;
    ok = (len >= 1) && (len <= NW);
    load_start = 1;
    load_len = 8'(len);
    if (!ok) ev_q.push_back('{2, 32'h0, cyc + 1});
    @(posedge cpu_clk); #1;
    load_start = 0;
    if (!ok) begin
      chk("err_pulse", load_err, 1);
      chk("err_cpu_hold", cpu_hold, 0);
      chk("err_src_ready", src_ready, 0);
      repeat (2) begin @(posedge cpu_clk); #1; end
      $display("load len=%0d rejected", len);
      return;
    end
    i = 0; guard = 0; gap_left = 2; sum = 0; last_cyc = 0;
    while (i < len && guard < 4 * len + 100) begin
      bubble = 0;
      if (mode == 1) bubble = ($urandom_range(0, 3) == 0);
      else if (mode == 2 && i == 1 && gap_left > 0) begin
        bubble = 1;
        gap_left--;
      end
      src_valid = !bubble;
      src_data = bubble ? $urandom : word_tab[i];
      rdy = src_ready;
      if (spur && rdy && $urandom_range(0, 7) == 0) begin
        load_start = 1;
        load_len = 8'd1;
      end
      @(posedge cpu_clk); #1;
      load_start = 0;
      guard++;
      if (src_valid && rdy) begin
        wr_q.push_back('{i, word_tab[i], cyc});
        sum = sum + word_tab[i];
        last_cyc = cyc;
        i++;
        if (i == abort_after) begin
          src_valid = 0;
          cpu_rst = 1;
          @(posedge cpu_clk); #1;
          cpu_rst = 0;
          chk_all_zero("abort");
          repeat (3) begin @(posedge cpu_clk); #1; end
          $display("load len=%0d aborted after %0d words", len, i);
          return;
        end
      end
    end
    src_valid = 0;
    chk("words_accepted", i, len);
    if (i == len) ev_q.push_back('{1, sum, last_cyc + 1});
    repeat (3) begin @(posedge cpu_clk); #1; end
    $display("load len=%0d mode=%0d done, csum=0x%08h", len, mode, sum);
  endtask

  task automatic fill_random(input int n);
    word_tab.delete();
    for (int k = 0; k < n; k++) word_tab.push_back($urandom);
  endtask

  initial begin
    cpu_rst = 1; load_start = 0; load_len = 0; src_valid = 0; src_data = 0;
    repeat (3) @(posedge cpu_clk);
    #1;
    chk_all_zero("reset");
    // reset must win over a simultaneous start request
    load_start = 1; load_len = 8'd3;
    @(posedge cpu_clk); #1;
    chk("rst_prio_busy", load_busy, 0);
    chk("rst_prio_hold", cpu_hold, 0);
    cpu_rst = 0; load_start = 0;
    @(posedge cpu_clk); #1;
    mon_en = 1;

    word_tab.delete();
    word_tab.push_back(32'h11); word_tab.push_back(32'h22); word_tab.push_back(32'h33);
    run_load(3, 0, 0, 0);

    fill_random(2);
    run_load(2, 2, 0, 0);

    run_load(0, 0, 0, 0);
    run_load(NW + 1, 0, 0, 0);

    fill_random(NW);
    run_load(NW, 0, 1, 0);

    fill_random(5);
    run_load(5, 0, 0, 2);

    word_tab.delete();
    word_tab.push_back(32'hFFFF_FFFF); word_tab.push_back(32'h0000_0002);
    run_load(2, 0, 0, 0);

    for (int r = 0; r < 25; r++) begin
      int len;
      if ($urandom_range(0, 9) == 0) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(NW + 1, 255));
        run_load(len, 0, 0, 0);
      end else begin
        len = $urandom_range(1, 10);
        fill_random(len);
        run_load(len, 1, 1, 0);
      end
    end

    repeat (5) @(posedge cpu_clk);
    #1;
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("ev_queue_drained", ev_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
